debounce_bank: RTL and testbench

Parametrised, multi-channel successor to the single-button debouncer. It sits between raw pushbutton or switch pins and user-control logic. For each channel it:
- synchronises the raw input;
- debounces both edges symmetrically;
- emits one-cycle press and release pulses;
- provides a long-press level and an optional auto-repeat pulse train.

---
 rtl/debounce_bank.sv | 74 +++++++
 tb/tb_debounce_bank.sv | 109 ++++++++++
 2 files changed

// File: rtl/debounce_bank.sv
// debounce_bank: per-channel synchroniser, symmetric debouncer, edge pulses, long-press and auto-repeat
module debounce_bank #(
  parameter int NCH = 4,
  parameter int NDELAY = 650000,
  parameter int NBITS = 20,
  parameter int REPEAT_START = 32500000,
  parameter int REPEAT_PERIOD = 6500000,
  parameter int RBITS = 26,
  parameter logic [NCH-1:0] REPEAT_EN = {NCH{1'b1}}
) (
  input  logic           clks,
  input  logic           reset,
  input  logic [NCH-1:0] noisy,
  output logic [NCH-1:0] clean,
  output logic [NCH-1:0] press_p,
  output logic [NCH-1:0] release_p,
  output logic [NCH-1:0] held,
  output logic [NCH-1:0] rpt_p
);
  typedef enum logic [1:0] {IDLE, WAIT, RPT} state_t;
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic s1, s2, xnew, c, pp, rp, rpt;
    logic [NBITS-1:0] count;
    logic [RBITS-1:0] hc, hc_n;
    state_t state, state_n;
    logic stable, rise, fall, fire;
    assign stable = (s2 == xnew) && (count == NBITS'(NDELAY));
    assign rise = stable && xnew && !c;
    assign fall = stable && !xnew && c;
    // a release takes priority over a repeat boundary landing on the same edge
    always_comb begin
      state_n = state;
      hc_n = hc;
      fire = 1'b0;
      if (fall) begin
        state_n = IDLE;
        hc_n = '0;
      end else if (rise) begin
        state_n = WAIT;
        hc_n = '0;
      end else if (state != IDLE) begin
        fire = hc == ((state == WAIT) ? RBITS'(REPEAT_START - 1) : RBITS'(REPEAT_PERIOD - 1));
        state_n = fire ? RPT : state;
        hc_n = fire ? '0 : hc + RBITS'(1);
      end
    end
    always_ff @(posedge clks) begin
      if (reset) begin
        {s1, s2, xnew, c, pp, rp, rpt} <= '0;
        count <= '0;
        hc <= '0;
        state <= IDLE;
      end else begin
        s1 <= noisy[i];
        s2 <= s1;
        if (s2 != xnew) begin
          xnew <= s2;
          count <= '0;
        end else if (count != NBITS'(NDELAY)) count <= count + NBITS'(1);
        c <= stable ? xnew : c;
        pp <= rise;
        rp <= fall;
        rpt <= fire && REPEAT_EN[i];
        state <= state_n;
        hc <= hc_n;
      end
    end
    assign clean[i] = c;
    assign press_p[i] = pp;
    assign release_p[i] = rp;
    assign rpt_p[i] = rpt;
    assign held[i] = state == RPT;
  end
endmodule

// File: tb/tb_debounce_bank.sv
// tb_debounce_bank: directed checks of debounce latency, glitch filtering, hold and repeat timing
module tb_debounce_bank;
  logic clks = 0, reset = 1;
  logic [3:0] noisy = '0, clean, press_p, release_p, held, rpt_p;
  int n_cmp = 0, n_bad = 0, t = 0, ov = 0;
  int np[4], nr[4], nrp[4], fp[4], fr[4], frp[4], lrp[4], fh[4], lh[4];

  debounce_bank #(.NCH(4), .NDELAY(4), .NBITS(3), .REPEAT_START(10), .REPEAT_PERIOD(3),
                  .RBITS(4), .REPEAT_EN(4'b0111)) dut (
    .clks(clks), .reset(reset), .noisy(noisy), .clean(clean), .press_p(press_p),
    .release_p(release_p), .held(held), .rpt_p(rpt_p));

  always #5 clks = ~clks;

  task automatic clr();
    t = 0;
    for (int c = 0; c < 4; c++) begin
      np[c] = 0; nr[c] = 0; nrp[c] = 0;
      fp[c] = -1; fr[c] = -1; frp[c] = -1; lrp[c] = -1; fh[c] = -1; lh[c] = -1;
    end
  endtask

  // t = number of edges since clr; observations taken 1 time unit after each edge
  task automatic watch(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clks); #1; t++;
      for (int c = 0; c < 4; c++) begin
        if (press_p[c]) begin np[c]++; if (fp[c] < 0) fp[c] = t; end
        if (release_p[c]) begin nr[c]++; if (fr[c] < 0) fr[c] = t; end
        if (rpt_p[c]) begin nrp[c]++; if (frp[c] < 0) frp[c] = t; lrp[c] = t; end
        if (held[c]) begin if (fh[c] < 0) fh[c] = t; lh[c] = t; end
        if ($countones({press_p[c], release_p[c], rpt_p[c]}) > 1) ov++;
      end
    end
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  initial begin
    clr();
    watch(2);
    chk("reset_outs", int'({clean, press_p, release_p, held, rpt_p}), 0);
    reset = 0;
    // 1: clean press on ch0
    clr(); noisy[0] = 1; watch(12);
    chk("t1_press_at", fp[0], 8);
    chk("t1_press_cnt", np[0], 1);
    chk("t1_clean", int'(clean), 1);
    chk("t1_other_press", np[1] + np[2] + np[3], 0);
    chk("t1_no_rpt_held", nrp[0] + nrp[1] + nrp[2] + nrp[3] + (fh[0] + 1), 0);
    // 2: bounce on ch1
    clr(); noisy[1] = 1; watch(3);
    for (int k = 0; k < 7; k++) begin noisy[1] = ~noisy[1]; watch(3); end
    chk("t2_no_pulse_bounce", np[1] + nr[1], 0);
    noisy[1] = 1; watch(12);
    chk("t2_press_at", fp[1], 32);
    chk("t2_press_cnt", np[1], 1);
    // 3: release glitch then real release on ch0
    clr(); noisy[0] = 0; watch(4); noisy[0] = 1; watch(10);
    chk("t3_glitch_clean", int'(clean[0]), 1);
    chk("t3_glitch_rel", nr[0], 0);
    clr(); noisy[0] = 0; watch(10);
    chk("t3_rel_at", fr[0], 8);
    chk("t3_rel_cnt", nr[0], 1);
    chk("t3_clean", int'(clean[0]), 0);
    // 4: hold and repeat on ch2, release on a repeat boundary
    clr(); noisy[2] = 1; watch(49);
    chk("t4_press_at", fp[2], 8);
    chk("t4_held_at", fh[2], 18);
    chk("t4_rpt_first", frp[2], 18);
    chk("t4_rpt_cnt", nrp[2], 11);
    chk("t4_rpt_last", lrp[2], 48);
    clr(); noisy[2] = 0; watch(12);
    chk("t4_rel_at", fr[2], 8);
    chk("t4_held_last", lh[2], 7);
    chk("t4_rpt_after", nrp[2], 2);
    chk("t4_rpt_last_rel", lrp[2], 5);
    clr(); noisy[3] = 1; watch(30);
    chk("t4_ch3_held_at", fh[3], 18);
    chk("t4_ch3_no_rpt", nrp[3], 0);
    chk("t4_ch3_press", np[3], 1);
    clr(); noisy[3] = 0; watch(12);
    chk("t4_ch3_rel", nr[3], 1);
    chk("t4_ch3_held_end", int'(held[3]), 0);
    // 5: reset while held
    clr(); noisy[2] = 1; watch(20);
    chk("t5_held", int'(held[2]), 1);
    clr(); reset = 1; watch(1);
    chk("t5_rst_outs", int'({clean, press_p, release_p, held, rpt_p}), 0);
    reset = 0; watch(12);
    chk("t5_press_at", fp[2], 9);
    chk("t5_no_rel", nr[2], 0);
    chk("t5_press_cnt", np[2], 1);
    // 6: simultaneous channels, bounce on ch3 only
    clr(); noisy[0] = 1; noisy[3] = 1; watch(2); noisy[3] = 0; watch(2); noisy[3] = 1; watch(12);
    chk("t6_ch0_at", fp[0], 8);
    chk("t6_ch3_at", fp[3], 12);
    chk("t6_press_cnt", np[0] * 10 + np[3], 11);
    chk("no_overlap", ov, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
